adder_gather: RTL and testbench

- Serial-to-parallel input stage that sits directly upstream of the adder tree.
- Accepts one BITS-wide word per handshake and packs NUM consecutive words into a registered frame.
- Presents the frame with a one-cycle valid pulse, which drives the adder's valid/data_inN inputs.
- Short frames terminated by in_last are zero-padded, so the adder sum is unaffected.

---
 rtl/adder_gather.sv | 98 +++++++++
 tb/tb_adder_gather.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_gather.sv
// Serial-to-parallel gather stage in front of the adder tree. It packs NUM accepted
// words into one registered frame and zero-pads frames that in_last closes early.
module adder_gather #(
  parameter int BITS = 8,
  parameter int NUM  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                valid_out,
  output logic [NUM*BITS-1:0] data_out,
  output logic [NUM-1:0]      pad_mask,
  output logic [15:0]         frame_cnt
);

  localparam int IW = $clog2(NUM);

  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM-2:0][BITS-1:0]     shadow_q, shadow_d;
  logic                         valid_q, valid_d;
  logic [NUM-1:0][BITS-1:0]     data_q, data_d;
  logic [NUM-1:0]               pad_q, pad_d;
  logic [15:0]                  cnt_q, cnt_d;

  logic                         accept;
  logic                         complete;
  logic [NUM-1:0][BITS-1:0]     lane_src;
  logic [NUM-1:0]               lane_pad;

  // Frame as it would look if the current word closed it: stored lanes below idx,
  // the live word at idx, zeros above. The top lane can only ever be the live word.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    if (i < NUM - 1) begin : g_stored
      assign lane_src[i] = (IW'(i) < idx_q)  ? shadow_q[i] :
                           (IW'(i) == idx_q) ? in_data     : '0;
    end else begin : g_top
      assign lane_src[i] = (IW'(i) == idx_q) ? in_data : '0;
    end
    assign lane_pad[i] = (IW'(i) > idx_q);
  end

  // Ready drops during reset and during a flush; downstream can never stall us.
  assign in_ready = ~rst & ~clear;
  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (idx_q == IW'(NUM - 1)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    idx_d    = idx_q;
    shadow_d = shadow_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    pad_d    = pad_q;
    cnt_d    = cnt_q;
    if (clear) begin
      idx_d    = '0;
      shadow_d = '0;
    end else if (complete) begin
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = lane_src;
      pad_d   = lane_pad;
      cnt_d   = cnt_q + 16'd1;
    end else if (accept) begin
      shadow_d[idx_q] = in_data;
      idx_d           = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      idx_q    <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      pad_q    <= '0;
      cnt_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      pad_q    <= pad_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign pad_mask  = pad_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_adder_gather.sv
// Self-checking bench for adder_gather: table-driven frames, hand-written corner
// sequences and randomized traffic, all checked against a queue-based frame model.
module tb_adder_gather;

  localparam int BITS = 8;
  localparam int NUM  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic [BITS-1:0]   in_data;
  logic              in_last;
  logic              in_ready;
  logic              valid_out;
  logic [NUM*BITS-1:0] data_out;
  logic [NUM-1:0]    pad_mask;
  logic [15:0]       frame_cnt;

  adder_gather #(.BITS(BITS), .NUM(NUM)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .pad_mask  (pad_mask),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words of the frame being built, plus the last emitted frame.
  logic [BITS-1:0]     cur[$];
  logic                exp_valid;
  logic [NUM*BITS-1:0] exp_data;
  logic [NUM-1:0]      exp_pad;
  logic [15:0]         exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_pad   = '0;
    exp_cnt   = '0;
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare all outputs.
  task automatic send(input logic v, input logic [BITS-1:0] d, input logic l, input logic c);
    logic [NUM-1:0] ones;
    ones     = '1;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    clear    = c;
    #1;
    check("in_ready", in_ready, !c);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (c) begin
      cur.delete();
    end else if (v) begin
      cur.push_back(d);
      if (l || cur.size() == NUM) begin
        exp_data = '0;
        for (int i = 0; i < cur.size(); i++) exp_data[i*BITS +: BITS] = cur[i];
        exp_pad   = ones << cur.size();
        exp_cnt   = exp_cnt + 16'd1;
        exp_valid = 1'b1;
        cur.delete();
      end
    end
    check("valid_out", valid_out, exp_valid);
    check("data_out", data_out, exp_data);
    check("pad_mask", pad_mask, exp_pad);
    check("frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic idle();
    send(1'b0, $urandom_range(0, 255), $urandom_range(0, 1), 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop without a clock.
  task automatic async_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst valid_out", valid_out, 1'b0);
    check("rst data_out", data_out, '0);
    check("rst pad_mask", pad_mask, '0);
    check("rst frame_cnt", frame_cnt, '0);
    check("rst in_ready", in_ready, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int                  n;
    logic [NUM*BITS-1:0] words;
    logic                last;
    logic [NUM*BITS-1:0] exp_data;
    logic [NUM-1:0]      exp_pad;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{n: 4, words: 32'h04030201, last: 1'b0, exp_data: 32'h04030201, exp_pad: 4'b0000};
    vecs[1] = '{n: 2, words: 32'h0000BBAA, last: 1'b1, exp_data: 32'h0000BBAA, exp_pad: 4'b1100};
    vecs[2] = '{n: 1, words: 32'h000000CC, last: 1'b1, exp_data: 32'h000000CC, exp_pad: 4'b1110};
    vecs[3] = '{n: 4, words: 32'hA4A3A2A1, last: 1'b1, exp_data: 32'hA4A3A2A1, exp_pad: 4'b0000};
    vecs[4] = '{n: 3, words: 32'h00070605, last: 1'b1, exp_data: 32'h00070605, exp_pad: 4'b1000};

    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    model_reset();
    #2;
    check("por valid_out", valid_out, 1'b0);
    check("por data_out", data_out, '0);
    check("por pad_mask", pad_mask, '0);
    check("por frame_cnt", frame_cnt, '0);
    check("por in_ready", in_ready, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ready after reset", in_ready, 1'b1);

    // Table-driven frames: full, short, single-word, last-on-final-lane, three-word.
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < vecs[k].n; j++)
        send(1'b1, vecs[k].words[j*BITS +: BITS], vecs[k].last && (j == vecs[k].n - 1), 1'b0);
      check("tbl valid", valid_out, 1'b1);
      check("tbl data", data_out, vecs[k].exp_data);
      check("tbl pad", pad_mask, vecs[k].exp_pad);
      check("tbl cnt", frame_cnt, 16'(k + 1));
      idle();
      check("tbl pulse ends", valid_out, 1'b0);
      check("tbl data holds", data_out, vecs[k].exp_data);
    end

    // Back-to-back streaming of 0x10..0x17: pulses after the 4th and 8th accepts.
    async_reset();
    for (int j = 0; j < 8; j++) begin
      send(1'b1, 8'(8'h10 + j), 1'b0, 1'b0);
      check("b2b pulse", valid_out, (j == 3) || (j == 7));
      if (j == 3) check("b2b frame0", data_out, 32'h13121110);
    end
    check("b2b frame1", data_out, 32'h17161514);
    check("b2b cnt", frame_cnt, 16'd2);

    // Clear after two words; the word offered during clear is dropped.
    send(1'b1, 8'h11, 1'b0, 1'b0);
    send(1'b1, 8'h22, 1'b0, 1'b0);
    send(1'b1, 8'h99, 1'b0, 1'b1);
    check("clear keeps cnt", frame_cnt, 16'd2);
    send(1'b1, 8'h33, 1'b0, 1'b0);
    send(1'b1, 8'h44, 1'b0, 1'b0);
    send(1'b1, 8'h55, 1'b0, 1'b0);
    send(1'b1, 8'h66, 1'b0, 1'b0);
    check("clear frame", data_out, 32'h66554433);
    check("clear cnt", frame_cnt, 16'd3);

    // Reset mid-frame after three words, then a clean frame.
    send(1'b1, 8'hE1, 1'b0, 1'b0);
    send(1'b1, 8'hE2, 1'b0, 1'b0);
    send(1'b1, 8'hE3, 1'b0, 1'b0);
    async_reset();
    for (int j = 0; j < 4; j++) send(1'b1, 8'(8'h91 + j), 1'b0, 1'b0);
    check("post-rst frame", data_out, 32'h94939291);
    check("post-rst pad", pad_mask, 4'b0000);
    check("post-rst cnt", frame_cnt, 16'd1);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++)
      send($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 6) == 0,
           $urandom_range(0, 19) == 0);

    // Counter wrap: 65536 single-word frames from a fresh reset.
    async_reset();
    for (int t = 0; t < 65536; t++) send(1'b1, 8'($urandom), 1'b1, 1'b0);
    check("wrap cnt", frame_cnt, 16'd0);
    idle();
    check("wrap pulse ends", valid_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
